// File: rtl/mips_pkg.sv
// Shared helpers for the MIPS branch predictor: saturating counter arithmetic,
// weak-state constants and PC index/tag slicing.
package mips_pkg;

   // Largest representable counter value for a counter of width w.
   function automatic logic [31:0] ctr_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // Saturating increment of a w-bit counter held in the low bits of v.
   function automatic logic [31:0] ctr_inc(input logic [31:0] v, input int unsigned w);
      return (v >= ctr_max(w)) ? ctr_max(w) : (v + 32'd1);
   endfunction

   // Saturating decrement, floor at zero.
   function automatic logic [31:0] ctr_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : (v - 32'd1);
   endfunction

   // Weakly taken: MSB set, all lower bits clear.
   function automatic logic [31:0] weak_taken(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   // Weakly not-taken: one below weakly taken.
   function automatic logic [31:0] weak_not_taken(input int unsigned w);
      return weak_taken(w) - 32'd1;
   endfunction

   // Table index: word-aligned PC bits just above the byte offset.
   function automatic logic [31:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
      return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
   endfunction

   // Tag: the tag_w bits immediately above the index.
   function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                          input int unsigned tag_w);
      return 32'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
   endfunction

endpackage

// File: rtl/mips_satctr.sv
// Single saturating up/down counter with parallel load. Resets to weakly
// not-taken. Load has priority over inc, inc over dec.
module mips_satctr
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_d, value_q;

   // Next counter value.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = WIDTH'(ctr_inc(32'(value_q), WIDTH));
      end else if (dec) begin
         value_d = WIDTH'(ctr_dec(32'(value_q)));
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= WIDTH'(weak_not_taken(WIDTH));
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/mips_bpred.sv
// Direct-mapped dynamic branch predictor beside the IF stage.
// Combinational lookup on the fetch PC; one training update per cycle from the
// resolving stage. Optional statistics counters when BPRED_STATS_EN is defined.
module mips_bpred
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned CTR_WIDTH  = 2,
   parameter int unsigned TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lookup_valid,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  pred_hit,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_target,
   input  logic                  update_valid,
   input  logic [ADDR_WIDTH-1:0] update_pc,
   input  logic                  update_taken,
   input  logic [ADDR_WIDTH-1:0] update_target,
   input  logic                  update_pred_taken,
   input  logic                  flush_all
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]           stat_updates,
   output logic [31:0]           stat_mispredicts
`endif
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0]                valid_q;
   logic [TAG_WIDTH-1:0]              tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0]             target_q [ENTRIES];
   logic [ENTRIES-1:0][CTR_WIDTH-1:0] ctr_val;

   logic [IDX_W-1:0]     lk_idx, up_idx;
   logic [TAG_WIDTH-1:0] lk_tag, up_tag;
   logic                 lk_hit, up_hit;

   assign lk_idx = IDX_W'(pc_idx(64'(lookup_pc), IDX_W));
   assign lk_tag = TAG_WIDTH'(pc_tag(64'(lookup_pc), IDX_W, TAG_WIDTH));
   assign up_idx = IDX_W'(pc_idx(64'(update_pc), IDX_W));
   assign up_tag = TAG_WIDTH'(pc_tag(64'(update_pc), IDX_W, TAG_WIDTH));

   // Lookup reads pre-update state; no bypass from a same-cycle update.
   always_comb begin
      lk_hit      = lookup_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_hit    = lk_hit;
      pred_taken  = lk_hit && ctr_val[lk_idx][CTR_WIDTH-1];
      pred_target = pred_taken ? target_q[lk_idx] : '0;
   end

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // One counter per entry; flush suppresses any training in that cycle.
   for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      logic sel;
      assign sel = update_valid && !flush_all && (up_idx == IDX_W'(i));

      mips_satctr #(
         .WIDTH (CTR_WIDTH)
      ) u_ctr (
         .clk      (clk),
         .reset    (reset),
         .inc      (sel && up_hit && update_taken),
         .dec      (sel && up_hit && !update_taken),
         .load     (sel && !up_hit && update_taken),
         .load_val (CTR_WIDTH'(weak_taken(CTR_WIDTH))),
         .value    (ctr_val[i])
      );
   end

   // Valid/tag/target state: any taken update (hit or allocate) writes the entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (update_valid && update_taken) begin
         valid_q[up_idx]  <= 1'b1;
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= update_target;
      end
   end

`ifdef BPRED_STATS_EN
   // Saturating statistics; unaffected by flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_updates     <= '0;
         stat_mispredicts <= '0;
      end else if (update_valid) begin
         if (stat_updates != 32'hFFFF_FFFF) begin
            stat_updates <= stat_updates + 32'd1;
         end
         if ((update_taken != update_pred_taken) && (stat_mispredicts != 32'hFFFF_FFFF)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`else
   logic unused_pred_taken;
   assign unused_pred_taken = update_pred_taken;
`endif

endmodule

// File: tb/tb_mips_bpred.sv
// Self-checking bench for mips_bpred: directed vector table, hand-written reset
// sequence, then randomized traffic against a behavioural table model.
module tb_mips_bpred;

   localparam int AW   = 32;
   localparam int ENT  = 16;
   localparam int CW   = 2;
   localparam int TW   = 8;
   localparam int CMAX = (1 << CW) - 1;
   localparam int WT   = 1 << (CW - 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          lookup_valid;
   logic [AW-1:0] lookup_pc;
   logic          pred_hit;
   logic          pred_taken;
   logic [AW-1:0] pred_target;
   logic          update_valid;
   logic [AW-1:0] update_pc;
   logic          update_taken;
   logic [AW-1:0] update_target;
   logic          update_pred_taken;
   logic          flush_all;
`ifdef BPRED_STATS_EN
   logic [31:0]   stat_updates;
   logic [31:0]   stat_mispredicts;
`endif

   always #5 clk = ~clk;

   mips_bpred #(
      .ADDR_WIDTH (AW),
      .ENTRIES    (ENT),
      .CTR_WIDTH  (CW),
      .TAG_WIDTH  (TW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .pred_hit          (pred_hit),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_pred_taken (update_pred_taken),
      .flush_all         (flush_all)
`ifdef BPRED_STATS_EN
      ,
      .stat_updates      (stat_updates),
      .stat_mispredicts  (stat_mispredicts)
`endif
   );

   typedef struct {
      bit          lv;
      logic [31:0] lpc;
      bit          uv;
      logic [31:0] upc;
      bit          ut;
      logic [31:0] utgt;
      bit          upt;
      bit          fl;
      bit          e_hit;
      bit          e_taken;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vecs[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model of the table contents.
   bit          m_valid [ENT];
   int          m_tag   [ENT];
   int          m_ctr   [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_upd   = 0;
   int          m_mis   = 0;

   function automatic void model_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_ctr[i]   = WT - 1;
         m_tgt[i]   = 0;
      end
      m_upd = 0;
      m_mis = 0;
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % ENT);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc / (4 * ENT)) % (1 << TW));
   endfunction

   // Apply one clock edge's worth of training to the model.
   function automatic void model_update(input bit uv, input logic [31:0] upc, input bit ut,
                                        input logic [31:0] utgt, input bit upt, input bit fl);
      int i;
      int t;
      if (uv) begin
         m_upd++;
         if (ut != upt) m_mis++;
      end
      if (fl) begin
         for (int k = 0; k < ENT; k++) m_valid[k] = 0;
         return;
      end
      if (!uv) return;
      i = idx_of(upc);
      t = tag_of(upc);
      if (m_valid[i] && m_tag[i] == t) begin
         if (ut) begin
            m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
            m_tgt[i] = utgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (ut) begin
         m_valid[i] = 1;
         m_tag[i]   = t;
         m_ctr[i]   = WT;
         m_tgt[i]   = utgt;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and settle.
   task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit upt, input bit fl);
      @(negedge clk);
      lookup_valid      = lv;
      lookup_pc         = lpc;
      update_valid      = uv;
      update_pc         = upc;
      update_taken      = ut;
      update_target     = utgt;
      update_pred_taken = upt;
      flush_all         = fl;
      #1;
   endtask

   task automatic commit();
      @(posedge clk);
      model_update(update_valid, update_pc, update_taken, update_target, update_pred_taken,
                   flush_all);
   endtask

   task automatic add(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit upt, input bit fl,
                      input bit eh, input bit et, input logic [31:0] eg);
      vec_t v;
      v = '{lv, lpc, uv, upc, ut, utgt, upt, fl, eh, et, eg};
      vecs.push_back(v);
   endtask

   initial begin
      int          li;
      int          lt;
      bit          eh;
      bit          et;
      logic [31:0] eg;
      logic [31:0] lpc;
      logic [31:0] upc;

      reset = 1'b0;
      lookup_valid = 1'b1;
      lookup_pc = 32'h40;
      update_valid = 1'b0;
      update_pc = '0;
      update_taken = 1'b0;
      update_target = '0;
      update_pred_taken = 1'b0;
      flush_all = 1'b0;
      model_reset();

      // Directed table: expected outputs are the lookup seen before the edge.
      //   lv  lpc     uv upc     ut tgt      upt fl  hit tk target
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h40,  1, 32'h40, 1, 32'h100, 0,  0,  0, 0, 32'h0);
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  1, 1, 32'h100);
      add(1, 32'h40,  1, 32'h40, 0, 32'h0,   1,  0,  1, 1, 32'h100);
      add(1, 32'h40,  1, 32'h40, 0, 32'h0,   0,  0,  1, 0, 32'h0);
      add(1, 32'h40,  1, 32'h40, 0, 32'h0,   0,  0,  1, 0, 32'h0);
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  1, 0, 32'h0);
      add(1, 32'h40,  1, 32'h40, 1, 32'h100, 0,  0,  1, 0, 32'h0);
      add(1, 32'h40,  1, 32'h40, 1, 32'h100, 0,  0,  1, 0, 32'h0);
      add(1, 32'h40,  1, 32'h40, 1, 32'h100, 1,  0,  1, 1, 32'h100);
      add(1, 32'h40,  1, 32'h40, 1, 32'h100, 1,  0,  1, 1, 32'h100);
      add(1, 32'h40,  1, 32'h40, 0, 32'h0,   1,  0,  1, 1, 32'h100);
      add(1, 32'h40,  1, 32'h40, 0, 32'h0,   1,  0,  1, 1, 32'h100);
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  1, 0, 32'h0);
      add(1, 32'h440, 0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h440, 1, 32'h440,1, 32'h200, 0,  0,  0, 0, 32'h0);
      add(1, 32'h440, 0, 32'h0,  0, 32'h0,   0,  0,  1, 1, 32'h200);
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h80,  1, 32'h80, 1, 32'h300, 0,  0,  0, 0, 32'h0);
      add(1, 32'h80,  0, 32'h0,  0, 32'h0,   0,  0,  1, 1, 32'h300);
      add(1, 32'hC0,  1, 32'hC0, 0, 32'h0,   1,  0,  0, 0, 32'h0);
      add(1, 32'hC0,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(0, 32'h80,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h80,  1, 32'h40, 1, 32'h500, 0,  1,  1, 1, 32'h300);
      add(1, 32'h80,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h40,  0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);
      add(1, 32'h440, 0, 32'h0,  0, 32'h0,   0,  0,  0, 0, 32'h0);

      // Reset state while reset is held.
      #2;
      check("reset_hit", 32'(pred_hit), 32'd0);
      check("reset_taken", 32'(pred_taken), 32'd0);
      check("reset_target", pred_target, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         drive(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt,
               vecs[i].upt, vecs[i].fl);
         check($sformatf("vec%0d_hit", i), 32'(pred_hit), 32'(vecs[i].e_hit));
         check($sformatf("vec%0d_taken", i), 32'(pred_taken), 32'(vecs[i].e_taken));
         check($sformatf("vec%0d_target", i), pred_target, vecs[i].e_tgt);
         commit();
      end

`ifdef BPRED_STATS_EN
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      check("stat_updates", stat_updates, 32'(m_upd));
      check("stat_mispredicts", stat_mispredicts, 32'(m_mis));
      commit();
`endif

      // Mid-run asynchronous reset clears outputs within the same cycle.
      drive(0, 32'h0, 1, 32'h80, 1, 32'h300, 1, 0);
      commit();
      drive(1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 0);
      check("pre_reset_hit", 32'(pred_hit), 32'd1);
      reset = 1'b0;
      #1;
      check("async_reset_hit", 32'(pred_hit), 32'd0);
      check("async_reset_taken", 32'(pred_taken), 32'd0);
      check("async_reset_target", pred_target, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_reset_hit", 32'(pred_hit), 32'd0);
`ifdef BPRED_STATS_EN
      check("post_reset_stat_updates", stat_updates, 32'd0);
`endif

      // Randomized traffic over a few tags and all indices.
      for (int n = 0; n < 600; n++) begin
         lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
         upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
         drive(($urandom_range(0, 7) != 0), lpc, $urandom_range(0, 1) == 1, upc,
               $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
               $urandom_range(0, 31) == 0);
         li = idx_of(lookup_pc);
         lt = tag_of(lookup_pc);
         eh = lookup_valid && m_valid[li] && (m_tag[li] == lt);
         et = eh && (m_ctr[li] >= WT);
         eg = et ? m_tgt[li] : 32'h0;
         check("rand_hit", 32'(pred_hit), 32'(eh));
         check("rand_taken", 32'(pred_taken), 32'(et));
         check("rand_target", pred_target, eg);
         commit();
      end

`ifdef BPRED_STATS_EN
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      check("rand_stat_updates", stat_updates, 32'(m_upd));
      check("rand_stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
